// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes RV32I immediates, sign-extends to XLEN,
// and queues results with their tags in an in-order FIFO with valid/ready on both sides.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      illegal_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [2:0] FMT_NONE    = 3'd0;
    localparam logic [2:0] FMT_I       = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_J       = 3'd5;
    localparam logic [2:0] FMT_ILLEGAL = 3'd7;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready comes only from registered occupancy, so a pop never frees a slot in the same cycle.
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    always_comb begin
        dec_imm32   = 32'd0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (in_inst[6:0])
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_inst[31:12], 12'd0};
            end
            7'b0110011: dec_fmt = FMT_NONE;
            default: begin
                dec_fmt     = FMT_ILLEGAL;
                dec_illegal = 1'b1;
            end
        endcase
        // Every 32-bit immediate is already sign-correct at bit 31; widen from there.
        dec_imm       = {XLEN{dec_imm32[31]}};
        dec_imm[31:0] = dec_imm32;
    end

    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [2:0]       fmt_q [DEPTH];
    logic             ill_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [15:0]      ill_cnt_q, ill_cnt_d;
    logic             push, pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        ill_cnt_d = ill_cnt_q;
        if (push && dec_illegal && (ill_cnt_q != 16'hFFFF)) ill_cnt_d = ill_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                ill_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
            if (push) begin
                imm_q[wr_ptr_q] <= dec_imm;
                fmt_q[wr_ptr_q] <= dec_fmt;
                ill_q[wr_ptr_q] <= dec_illegal;
                tag_q[wr_ptr_q] <= in_tag;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign out_imm       = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_fmt       = out_valid ? fmt_q[rd_ptr_q] : 3'd0;
    assign out_illegal   = out_valid ? ill_q[rd_ptr_q] : 1'b0;
    assign out_tag       = out_valid ? tag_q[rd_ptr_q] : '0;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag;
    logic [2:0]  out_fmt;
    logic [15:0] illegal_count;

    logic        w_in_ready, w_out_valid, w_out_illegal;
    logic [63:0] w_out_imm;
    logic [31:0] w_out_tag;
    logic [2:0]  w_out_fmt;
    logic [15:0] w_illegal_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag), .illegal_count(illegal_count)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_out_imm), .out_fmt(w_out_fmt),
        .out_illegal(w_out_illegal), .out_tag(w_out_tag), .illegal_count(w_illegal_count)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Push one word into an empty FIFO with out_ready=1, check the head one cycle later,
    // then check the FIFO drained to idle outputs.
    task automatic push_check(input string name, input logic [31:0] inst, input logic [31:0] tag,
                              input logic [31:0] exp_imm, input logic [2:0] exp_fmt,
                              input logic exp_ill);
        @(negedge clk);
        in_valid = 1'b1; in_inst = inst; in_tag = tag; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_imm"},   64'(out_imm), 64'(exp_imm));
        check({name, "_fmt"},   64'(out_fmt), 64'(exp_fmt));
        check({name, "_ill"},   64'(out_illegal), 64'(exp_ill));
        check({name, "_tag"},   64'(out_tag), 64'(tag));
        @(negedge clk);
        check({name, "_drained"}, 64'(out_valid), 64'd0);
        check({name, "_idle_imm"}, 64'(out_imm), 64'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_tag = 32'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd1);
        check("rst_count",     64'(illegal_count), 64'd0);
        check("rst_imm",       64'(out_imm), 64'd0);
        check("rst_fmt",       64'(out_fmt), 64'd0);
        check("rst_tag",       64'(out_tag), 64'd0);
        reset = 1'b0;

        push_check("jal",   32'h0040006F, 32'h0000_1000, 32'h0000_0004, 3'd5, 1'b0);
        push_check("beq",   32'hFE000EE3, 32'h0000_1004, 32'hFFFF_FFFC, 3'd3, 1'b0);
        push_check("sw",    32'hFE112E23, 32'h0000_1008, 32'hFFFF_FFFC, 3'd2, 1'b0);
        push_check("addi",  32'hFFF00093, 32'h0000_100C, 32'hFFFF_FFFF, 3'd1, 1'b0);
        push_check("add",   32'h002081B3, 32'h0000_1010, 32'h0000_0000, 3'd0, 1'b0);
        push_check("auipc", 32'h00001097, 32'h0000_1014, 32'h0000_1000, 3'd4, 1'b0);

        // 64-bit instance: zero- and sign-filled upper halves for LUI.
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h123452B7; in_tag = 32'h20;
        @(negedge clk);
        in_inst = 32'h800000B7; in_tag = 32'h24;
        check("lui64_pos_imm", w_out_imm, 64'h0000_0000_1234_5000);
        check("lui64_pos_fmt", 64'(w_out_fmt), 64'd4);
        check("lui32_pos_imm", 64'(out_imm), 64'h1234_5000);
        @(negedge clk);
        in_valid = 1'b0;
        check("lui64_neg_imm", w_out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui64_neg_tag", 64'(w_out_tag), 64'h24);
        check("lui32_neg_imm", 64'(out_imm), 64'h8000_0000);
        @(negedge clk);
        check("lui64_drained", 64'(w_out_valid), 64'd0);

        // Backpressure: fill, offer a third word while full, then drain in order.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00000013; in_tag = 32'hA;
        @(negedge clk);
        check("bp_ready_1", 64'(in_ready), 64'd1);
        in_tag = 32'hB;
        @(negedge clk);
        check("bp_full", 64'(in_ready), 64'd0);
        check("bp_head_a", 64'(out_tag), 64'hA);
        in_tag = 32'hC;
        @(negedge clk);
        check("bp_still_full", 64'(in_ready), 64'd0);
        check("bp_head_a2", 64'(out_tag), 64'hA);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_head_b", 64'(out_tag), 64'hB);
        check("bp_ready_after_pop", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_head_c", 64'(out_tag), 64'hC);
        check("bp_valid_c", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp_empty", 64'(out_valid), 64'd0);

        push_check("ill", 32'h0000007F, 32'h0000_0077, 32'h0, 3'd7, 1'b1);
        check("ill_count_1", 64'(illegal_count), 64'd1);

        // Asynchronous reset with two entries queued.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h00000000; in_tag = 32'h55;
        @(negedge clk);
        in_tag = 32'h66;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_full", 64'(in_ready), 64'd0);
        check("pre_rst_count", 64'(illegal_count), 64'd3);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready), 64'd1);
        check("arst_count",     64'(illegal_count), 64'd0);
        check("arst_tag",       64'(out_tag), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_empty", 64'(out_valid), 64'd0);

        // Saturation: stream illegal words at one per cycle.
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0000007F; in_tag = 32'h0;
        repeat (65534) @(negedge clk);
        check("sat_fffe", 64'(illegal_count), 64'hFFFE);
        @(negedge clk);
        check("sat_ffff", 64'(illegal_count), 64'hFFFF);
        repeat (3) @(negedge clk);
        check("sat_hold", 64'(illegal_count), 64'hFFFF);
        check("sat_hold64", 64'(w_illegal_count), 64'hFFFF);
        in_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
